// File: rtl/mdio_frame_engine.sv
// mdio_frame_engine
// Clause 22 MDIO management-frame serializer. Takes one read or write request
// at a time over a start/busy/done handshake, generates MDC with a clock-enable
// divider off clk, and drives/samples MDIO through split o/oe/i pins.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   start, read            request strobe (ignored while busy), 1 = read frame
//   phy_addr, reg_addr     PHYAD / REGAD fields
//   write_data             data for write frames
//   busy, done             frame in progress, one-clk end-of-frame pulse
//   read_data, rd_err      last read word, last read saw no TA response
//   mdc                    management clock
//   mdio_o, mdio_oe        MDIO drive value / enable (1 = drive)
//   mdio_i                 MDIO pin value
//
// state | meaning
// IDLE  | no frame; with busy=1 a request is latched and waits for a fall_tick
// PRE   | preamble ones, PRE_LEN bits
// CMD   | ST, OP, PHYAD, REGAD (14 bits)
// TA    | turnaround (2 bits); reads release MDIO here
// DATA  | 16 data bits, driven for writes, shifted in for reads
module mdio_frame_engine #(
  parameter int MODULE_CLK = 50_000_000,
  parameter int MDC_CLK    = 2_500_000,
  parameter int PRE_LEN    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        read,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] read_data,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int HALF = MODULE_CLK / (2 * MDC_CLK);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  if (HALF < 2) begin : g_half_chk
    $error("mdio_frame_engine: MODULE_CLK/(2*MDC_CLK) must be >= 2");
  end
  if (PRE_LEN < 1 || PRE_LEN > 32) begin : g_pre_chk
    $error("mdio_frame_engine: PRE_LEN must be in 1..32");
  end

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA} state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic          rd_q;

  logic tc, fall_tick, rise_tick;

  assign tc        = (div_cnt == CW'(HALF - 1));
  assign fall_tick = tc & mdc;
  assign rise_tick = tc & ~mdc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rd_q      <= 1'b0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      read_data <= 16'h0000;
      rd_err    <= 1'b0;
    end else begin
      done <= 1'b0;

      if (tc) begin
        div_cnt <= '0;
        mdc     <= ~mdc;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!busy) begin
            if (start) begin
              busy <= 1'b1;
              rd_q <= read;
              // Everything after the preamble goes out of one shift register.
              // For reads the TA/DATA slots hold ones; MDIO is released then.
              tx_sr <= {2'b01, (read ? 2'b10 : 2'b01), phy_addr, reg_addr,
                        (read ? 2'b11 : 2'b10), (read ? 16'hFFFF : write_data)};
            end
          end else if (fall_tick) begin
            state   <= PRE;
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b1;
            bit_cnt <= 5'(PRE_LEN - 1);
          end
        end

        PRE: begin
          if (fall_tick) begin
            if (bit_cnt == 5'd0) begin
              state   <= CMD;
              bit_cnt <= 5'd13;
              mdio_o  <= tx_sr[31];
              tx_sr   <= {tx_sr[30:0], 1'b1};
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        CMD: begin
          if (fall_tick) begin
            mdio_o <= tx_sr[31];
            tx_sr  <= {tx_sr[30:0], 1'b1};
            if (bit_cnt == 5'd0) begin
              state   <= TA;
              bit_cnt <= 5'd1;
              if (rd_q) mdio_oe <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        TA: begin
          // Second TA bit: a responding PHY pulls MDIO low.
          if (rise_tick && rd_q && bit_cnt == 5'd0) rd_err <= mdio_i;
          if (fall_tick) begin
            mdio_o <= tx_sr[31];
            tx_sr  <= {tx_sr[30:0], 1'b1};
            if (bit_cnt == 5'd0) begin
              state   <= DATA;
              bit_cnt <= 5'd15;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        DATA: begin
          if (rise_tick && rd_q) rx_sr <= {rx_sr[14:0], mdio_i};
          if (fall_tick) begin
            if (bit_cnt == 5'd0) begin
              state   <= IDLE;
              mdio_oe <= 1'b0;
              mdio_o  <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              if (rd_q) read_data <= rx_sr;
            end else begin
              mdio_o  <= tx_sr[31];
              tx_sr   <= {tx_sr[30:0], 1'b1};
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_frame_engine.sv
module tb_mdio_frame_engine;

  // HALF = 50e6 / (2 * 6.25e6) = 4 clk per MDC half period
  localparam int MODULE_CLK = 50_000_000;
  localparam int MDC_CLK    = 6_250_000;
  localparam int PRE_LEN    = 32;
  localparam int MDC_PER    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  phy_addr = '0;
  logic [4:0]  reg_addr = '0;
  logic [15:0] write_data = '0;
  logic        busy, done, rd_err, mdc, mdio_o, mdio_oe;
  logic [15:0] read_data;
  logic        mdio_i = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdio_frame_engine #(
    .MODULE_CLK(MODULE_CLK),
    .MDC_CLK(MDC_CLK),
    .PRE_LEN(PRE_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .read(read),
    .phy_addr(phy_addr),
    .reg_addr(reg_addr),
    .write_data(write_data),
    .busy(busy),
    .done(done),
    .read_data(read_data),
    .rd_err(rd_err),
    .mdc(mdc),
    .mdio_o(mdio_o),
    .mdio_oe(mdio_oe),
    .mdio_i(mdio_i)
  );

  // Line monitor and PHY model, all sampled on the clk falling edge.
  logic [63:0] phy_pattern = '1;
  int   cyc = 0;
  logic prev_mdc = 1'b0;
  bit   in_frame = 1'b0;
  int   fall_idx = 0;
  int   nrec = 0;
  logic rec_o  [0:4095];
  logic rec_oe [0:4095];
  int   ndone = 0;
  int   first_fall_cyc = 0;
  int   last_done_cyc = -1000;
  int   gap_cyc = 0;
  int   stray_oe = 0;

  always @(negedge clk) begin
    cyc++;
    if (!busy) in_frame = 1'b0;
    if (done) begin
      ndone++;
      last_done_cyc = cyc;
    end
    if (prev_mdc && !mdc) begin
      if (in_frame) begin
        fall_idx++;
      end else if (busy && mdio_oe) begin
        in_frame = 1'b1;
        fall_idx = 0;
        first_fall_cyc = cyc;
        gap_cyc = cyc - last_done_cyc;
      end
      if (in_frame && fall_idx < 64) mdio_i = phy_pattern[63 - fall_idx];
    end
    if (!prev_mdc && mdc && in_frame && nrec < 4096) begin
      rec_o[nrec]  = mdio_o;
      rec_oe[nrec] = mdio_oe;
      nrec++;
    end
    if (mdio_oe && !in_frame) stray_oe++;
    prev_mdc = mdc;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mdc !== 1'b0)     begin errors++; $display("FAIL rst_mdc got %b want 0", mdc); end
    checks++; if (mdio_o !== 1'b1)  begin errors++; $display("FAIL rst_mdio_o got %b want 1", mdio_o); end
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL rst_mdio_oe got %b want 0", mdio_oe); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL rst_read_data got %h want 0000", read_data); end
    checks++; if (rd_err !== 1'b0)  begin errors++; $display("FAIL rst_rd_err got %b want 0", rd_err); end
    rst = 1'b0;
  endtask

  task automatic test_write;
    logic [63:0] exp;
    int s, d0;
    bit ok;
    exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140};
    s = nrec; d0 = ndone;
    @(posedge clk); #1;
    read = 1'b0; phy_addr = 5'h01; reg_addr = 5'h00; write_data = 16'h1140; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_accept got %b want 1", busy); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_done_timeout got none want done"); end
    checks++; if (ndone != d0 + 1) begin errors++; $display("FAIL wr_done_count got %0d want %0d", ndone - d0, 1); end
    checks++; if (last_done_cyc - first_fall_cyc != 64 * MDC_PER) begin
      errors++; $display("FAIL wr_frame_len got %0d clk want %0d", last_done_cyc - first_fall_cyc, 64 * MDC_PER);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b want 0", busy); end
    checks++; if (nrec - s != 64) begin errors++; $display("FAIL wr_nbits got %0d want 64", nrec - s); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rec_o[s+i] !== exp[63-i] || rec_oe[s+i] !== 1'b1) begin
        errors++;
        $display("FAIL wr_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s+i], rec_oe[s+i], exp[63-i]);
      end
    end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL wr_read_data_kept got %h want 0000", read_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL wr_rd_err_kept got %b want 0", rd_err); end
  endtask

  task automatic test_read;
    logic [45:0] exp;
    int s, d0;
    bit ok;
    exp = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h01};
    phy_pattern = {32'hFFFF_FFFF, 14'h3FFF, 2'b10, 16'h796D};
    s = nrec; d0 = ndone;
    @(posedge clk); #1;
    read = 1'b1; phy_addr = 5'h01; reg_addr = 5'h01; write_data = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_done_timeout got none want done"); end
    checks++; if (ndone != d0 + 1) begin errors++; $display("FAIL rd_done_count got %0d want 1", ndone - d0); end
    checks++; if (read_data !== 16'h796D) begin errors++; $display("FAIL rd_data got %h want 796d", read_data); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", rd_err); end
    checks++; if (nrec - s != 64) begin errors++; $display("FAIL rd_nbits got %0d want 64", nrec - s); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (i < 46) begin
        if (rec_o[s+i] !== exp[45-i] || rec_oe[s+i] !== 1'b1) begin
          errors++;
          $display("FAIL rd_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s+i], rec_oe[s+i], exp[45-i]);
        end
      end else if (rec_oe[s+i] !== 1'b0) begin
        errors++;
        $display("FAIL rd_release%0d got oe=%b want oe=0", i, rec_oe[s+i]);
      end
    end
  endtask

  task automatic test_no_phy;
    int d0;
    bit ok;
    phy_pattern = '1;
    d0 = ndone;
    @(posedge clk); #1;
    read = 1'b1; phy_addr = 5'h07; reg_addr = 5'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nophy_done_timeout got none want done"); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL nophy_rd_err got %b want 1", rd_err); end
    checks++; if (read_data !== 16'hFFFF) begin errors++; $display("FAIL nophy_data got %h want ffff", read_data); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (ndone != d0 + 1) begin errors++; $display("FAIL nophy_done_count got %0d want 1", ndone - d0); end
  endtask

  task automatic test_busy;
    logic [63:0] exp;
    int s, d0;
    bit ok, hit;
    exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140};
    s = nrec; d0 = ndone;
    @(posedge clk); #1;
    read = 1'b0; phy_addr = 5'h01; reg_addr = 5'h00; write_data = 16'h1140; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (in_frame && fall_idx >= 20) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL busy_midframe_timeout got none want bit20"); end
    read = 1'b1; phy_addr = 5'h1F; reg_addr = 5'h1F; write_data = 16'hAAAA; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout got none want done"); end
    checks++; if (nrec - s != 64) begin errors++; $display("FAIL busy_nbits got %0d want 64", nrec - s); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rec_o[s+i] !== exp[63-i] || rec_oe[s+i] !== 1'b1) begin
        errors++;
        $display("FAIL busy_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s+i], rec_oe[s+i], exp[63-i]);
      end
    end
    checks++; if (read_data !== 16'hFFFF) begin errors++; $display("FAIL busy_read_data_kept got %h want ffff", read_data); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL busy_rd_err_kept got %b want 1", rd_err); end
    repeat (300) @(negedge clk);
    #1;
    checks++; if (ndone != d0 + 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", ndone - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] exp;
    int s, d0;
    bit ok, hit;
    d0 = ndone;
    @(posedge clk); #1;
    read = 1'b0; phy_addr = 5'h01; reg_addr = 5'h00; write_data = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (in_frame && fall_idx == 55) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_bit_timeout got none want data bit 7"); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mdc !== 1'b0)     begin errors++; $display("FAIL rstmid_mdc got %b want 0", mdc); end
    checks++; if (mdio_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got %b want 0", mdio_oe); end
    checks++; if (mdio_o !== 1'b1)  begin errors++; $display("FAIL rstmid_mdio_o got %b want 1", mdio_o); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL rstmid_read_data got %h want 0000", read_data); end
    checks++; if (rd_err !== 1'b0)  begin errors++; $display("FAIL rstmid_rd_err got %b want 0", rd_err); end
    repeat (300) @(negedge clk);
    #1;
    checks++; if (ndone != d0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", ndone - d0); end

    exp = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h03, 5'h04, 2'b10, 16'hBEEF};
    s = nrec;
    @(posedge clk); #1;
    read = 1'b0; phy_addr = 5'h03; reg_addr = 5'h04; write_data = 16'hBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_after_timeout got none want done"); end
    checks++; if (nrec - s != 64) begin errors++; $display("FAIL rstmid_after_nbits got %0d want 64", nrec - s); end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rec_o[s+i] !== exp[63-i] || rec_oe[s+i] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_after_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s+i], rec_oe[s+i], exp[63-i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp1, exp2;
    int s0, s1, d0, st0;
    bit ok, hit;
    exp1 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h0900};
    exp2 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h2100};
    s0 = nrec; d0 = ndone; st0 = stray_oe;
    @(posedge clk); #1;
    read = 1'b0; phy_addr = 5'h01; reg_addr = 5'h00; write_data = 16'h0900; start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL b2b_accept1 got busy=0 want 1"); end
    write_data = 16'h2100;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done1_timeout got none want done"); end
    s1 = nrec;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL b2b_accept2 got busy=0 want 1"); end
    start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done2_timeout got none want done"); end
    checks++; if (ndone != d0 + 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone - d0); end
    checks++; if (gap_cyc < MDC_PER) begin errors++; $display("FAIL b2b_gap got %0d clk want >= %0d", gap_cyc, MDC_PER); end
    checks++; if (stray_oe != st0) begin errors++; $display("FAIL b2b_idle_oe got %0d driven clk want 0", stray_oe - st0); end
    checks++; if (s1 - s0 != 64 || nrec - s1 != 64) begin
      errors++; $display("FAIL b2b_nbits got %0d,%0d want 64,64", s1 - s0, nrec - s1);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (rec_o[s0+i] !== exp1[63-i] || rec_oe[s0+i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_f1_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s0+i], rec_oe[s0+i], exp1[63-i]);
      end
      checks++;
      if (rec_o[s1+i] !== exp2[63-i] || rec_oe[s1+i] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_f2_bit%0d got o=%b oe=%b want o=%b oe=1", i, rec_o[s1+i], rec_oe[s1+i], exp2[63-i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
